text_renderer: RTL
==================

# text_renderer

Character-mode pixel generator for the VGA debug display. It takes pixel coordinates and sync signals from the VGA timing generator and holds an internal 80×30 character buffer with a write port for the debug logic. It drives the external 128×16 font ROM, which has an 11-bit address and an 8-bit row with 1-cycle synchronous read. It emits a pipelined 12-bit RGB pixel plus syncs delayed to match.

## Interface
Parameters:
- COLS, 80, text columns (8-pixel cells)
- ROWS, 30, text rows (16-pixel cells)
- FG_COLOR, 12'hFFF, foreground RGB444
- BG_COLOR, 12'h000, background RGB444
- BLINK_FRAMES, 30, frames per cursor blink half-period

Ports:
- clk  in  1  pixel clock; one clock domain only
- rst  in  1  reset, asynchronous, active-high
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- video_on  in  1  active-area flag
- hsync_in, vsync_in  in  1 each  syncs, active-low
- wr_en  in  1  buffer write strobe
- wr_addr  in  12  cell index, row*COLS+col
- wr_data  in  8  [6:0] char code, [7] inverse flag
- cursor_en  in  1  cursor enable
- cursor_pos  in  12  cursor cell index
- font_addr  out  11  {char[6:0], glyph_row[3:0]} to font ROM
- font_data  in  8  glyph row, valid 1 cycle after font_addr; bit 7 = leftmost pixel
- rgb  out  12  pixel colour
- hsync_out, vsync_out  out  1 each  syncs aligned with rgb

## Operation
- Cell: col = pixel_x[9:3], row = pixel_y[8:4], idx = row*COLS+col (12-bit, no overflow at 80×30).
- Pipeline:
  - Stage 0 (cycle N): read buffer at idx; register pixel_x[2:0], pixel_y[3:0], video_on, syncs, cursor_hit = cursor_en & (idx==cursor_pos).
  - Stage 1 (N+1): font_addr = {buf_q[6:0], y_d1} combinational from buffer output; delay inverse, cursor_hit, x, flags.
  - Stage 2 (N+2): bit = font_data[7 - x_d2]; on = bit ^ inverse_d2 ^ (cursor_hit_d2 & blink_phase); register rgb = video_on_d2 ? (on ? FG : BG) : 0.
- Buffer:
  - Dual-port, COLS*ROWS bytes.
  - Write is synchronous on wr_en; wr_addr ≥ COLS*ROWS is ignored.
  - Read-during-write to the same address returns old data.
  - Reset does not clear contents; power-up content is 0x00 (blank glyph).
- Blink:
  - A frame counter increments on each vsync_in falling edge (detected against a registered copy).
  - At count == BLINK_FRAMES-1 the counter wraps to 0 and blink_phase toggles.
  - The cursor shows only while blink_phase = 1.
- Cells with pixel_y ≥ ROWS*16 or pixel_x ≥ COLS*8 render BG when video_on is high.

## Timing
- Latency: 3 clk from pixel_x/pixel_y/syncs to rgb/hsync_out/vsync_out, constant with no stalls.
- Font ROM read is accounted for inside stage 1→2; font_addr is not registered in this block.
- Reset values:
  - rgb = 0; hsync_out = vsync_out = 1.
  - All pipeline flags are 0 and frame counter = 0.
  - blink_phase = 0; sync-edge register = 1.
- Reset mid-frame: outputs take their reset values immediately. After deassert, the first valid output is 3 cycles later.
- Write and pixel read may hit the same cell in the same cycle; the displayed pixel uses old data and the new char is visible from the next read.
- Simultaneous vsync edge and reset: reset wins.

## Structure
- Package text_pkg:
  - Constants: CHAR_W=8, CHAR_H=16, default COLS/ROWS, cell index width 12.
  - rgb444_t typedef.
  - Cell-byte field positions (CODE_MSB=6, INV_BIT=7).
- Sub-module text_buffer: simple dual-port RAM with 1 write port and 1 synchronous read port, old-data-on-collision, inferable as block RAM.
- The font ROM stays outside; the top level wires font_addr/font_data.

## Test plan
- Write 0x41 ('A') at cell 0; scan pixel_x 0..7 at pixel_y 3, video_on=1.
  - font_addr = 1043.
  - ROM row 00011000 gives rgb = FG at x=3,4 and BG elsewhere, each 3 cycles after its coordinate.
- Write 0xC1 at cell 0, same scan: pixels inverted (BG at x=3,4, FG elsewhere).
- Hold video_on=0 with toggling hsync_in/vsync_in: rgb = 0 and syncs reproduced exactly 3 cycles late.
- BLINK_FRAMES=2, cursor_en=1, cursor_pos=5, cell 5 = 0x00:
  - After 2 vsync falling edges, cell 5 renders all FG.
  - After 4 edges it renders BG again.
- Write to cell 10 in the same cycle the scan reads cell 10: old glyph displayed. Write to wr_addr=2400: buffer unchanged.
- Assert rst mid-line with blink_phase=1: rgb=0, syncs=1 immediately and blink_phase=0; valid pixels resume 3 cycles after deassert.

Source files
------------

// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared constants and types for the character-mode text renderer
package text_pkg;

  localparam int CHAR_W   = 8;
  localparam int CHAR_H   = 16;
  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;
  localparam int IDX_W    = 12;

  // cell byte layout: [6:0] glyph code, [7] inverse video
  localparam int CODE_MSB = 6;
  localparam int INV_BIT  = 7;

  typedef logic [11:0] rgb444_t;

endpackage

// File: rtl/text_buffer.sv
// rtl/text_buffer.sv - simple dual-port character buffer, old data returned on collision
module text_buffer
  import text_pkg::*;
#(
  parameter int DEPTH = DEF_COLS * DEF_ROWS
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  localparam logic [IDX_W-1:0] LIMIT = IDX_W'(DEPTH);

  logic [7:0] mem [DEPTH];

  // read and write share one edge, so a same-address read sees the pre-write byte
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < LIMIT)) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/text_renderer.sv
// rtl/text_renderer.sv - 3-stage character-mode pixel generator with blinking cursor
module text_renderer
  import text_pkg::*;
#(
  parameter int      COLS         = DEF_COLS,
  parameter int      ROWS         = DEF_ROWS,
  parameter rgb444_t FG_COLOR     = 12'hFFF,
  parameter rgb444_t BG_COLOR     = 12'h000,
  parameter int      BLINK_FRAMES = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic             video_on,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             cursor_en,
  input  logic [IDX_W-1:0] cursor_pos,
  output logic [10:0]      font_addr,
  input  logic [7:0]       font_data,
  output rgb444_t          rgb,
  output logic             hsync_out,
  output logic             vsync_out
);

  localparam int         CW    = $clog2(BLINK_FRAMES) + 1;
  localparam logic [9:0] X_END = 10'(COLS * CHAR_W);
  localparam logic [9:0] Y_END = 10'(ROWS * CHAR_H);

  logic [IDX_W-1:0] idx, rd_addr;
  logic             in_range;
  logic [7:0]       buf_q;

  assign idx      = IDX_W'(32'(pixel_y[8:4]) * COLS + 32'(pixel_x[9:3]));
  assign in_range = (pixel_x < X_END) && (pixel_y < Y_END);
  // off-screen coordinates still read a valid cell; their pixel is forced to BG later
  assign rd_addr  = in_range ? idx : '0;

  text_buffer #(.DEPTH(COLS * ROWS)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (buf_q)
  );

  logic [2:0] x_d1, x_d2;
  logic [3:0] y_d1;
  logic       vid_d1, vid_d2, rng_d1, rng_d2, hit_d1, hit_d2;
  logic       hs_d1, hs_d2, vs_d1, vs_d2, inv_d2;
  logic       vs_prev, blink_phase, pixel_on;
  logic [CW-1:0] frame_cnt;
  rgb444_t    pix;

  assign font_addr = {buf_q[CODE_MSB:0], y_d1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_d1 <= '0; y_d1 <= '0; vid_d1 <= 1'b0; rng_d1 <= 1'b0; hit_d1 <= 1'b0;
      hs_d1 <= 1'b1; vs_d1 <= 1'b1;
      x_d2 <= '0; inv_d2 <= 1'b0; vid_d2 <= 1'b0; rng_d2 <= 1'b0; hit_d2 <= 1'b0;
      hs_d2 <= 1'b1; vs_d2 <= 1'b1;
      rgb <= '0; hsync_out <= 1'b1; vsync_out <= 1'b1;
    end else begin
      x_d1   <= pixel_x[2:0];
      y_d1   <= pixel_y[3:0];
      vid_d1 <= video_on;
      rng_d1 <= in_range;
      hit_d1 <= cursor_en && (idx == cursor_pos);
      hs_d1  <= hsync_in;
      vs_d1  <= vsync_in;
      x_d2   <= x_d1;
      inv_d2 <= buf_q[INV_BIT];
      vid_d2 <= vid_d1;
      rng_d2 <= rng_d1;
      hit_d2 <= hit_d1;
      hs_d2  <= hs_d1;
      vs_d2  <= vs_d1;
      rgb       <= pix;
      hsync_out <= hs_d2;
      vsync_out <= vs_d2;
    end
  end

  // frame counter advances on each vsync falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev     <= 1'b1;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      vs_prev <= vsync_in;
      if (vs_prev && !vsync_in) begin
        if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pixel_on = font_data[3'd7 - x_d2] ^ inv_d2 ^ (hit_d2 & blink_phase);
    pix      = BG_COLOR;
    if (!vid_d2) begin
      pix = '0;
    end else if (rng_d2 && pixel_on) begin
      pix = FG_COLOR;
    end
  end

endmodule
